mem_stage: RTL

//   Consumer end of the EX/MEM pipeline register: MEM stage of the 5-stage pipeline.
//   - Drives the data memory over a req/ack handshake and stalls the pipeline while an access is outstanding.
//   - Resolves branch/jump redirects.
//   - Registers results into MEM/WB outputs for the WB stage.

---
 rtl/mem_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with req/ack data-memory access, timeout abort, redirect and MEM/WB register.
module mem_stage #(
  parameter int WIDTH   = 32,
  parameter int REGW    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             zero_i,
  input  logic [WIDTH-1:0] ALUResult_i,
  input  logic [WIDTH-1:0] WriteData_i,
  input  logic [REGW-1:0]  WriteReg_i,
  input  logic             RegWrite_i,
  input  logic             MemToReg_i,
  input  logic             MemWrite_i,
  input  logic             IsBranch_i,
  input  logic             IsJump_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic [WIDTH-1:0] target_o,
  output logic             err_o,
  output logic             RegWrite_o,
  output logic             MemToReg_o,
  output logic [WIDTH-1:0] ALUResult_o,
  output logic [WIDTH-1:0] ReadData_o,
  output logic [REGW-1:0]  WriteReg_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic req_q, req_d, we_q, we_d, err_q, err_d, rw_q, rw_d, m2r_q, m2r_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, alu_q, alu_d, rd_q, rd_d;
  logic [REGW-1:0] wr_q, wr_d;
  logic access, aligned, waiting, last, start, done, misaligned;
  assign access     = MemToReg_i | MemWrite_i;
  assign aligned    = ALUResult_i[1:0] == 2'b00;
  assign waiting    = state_q == WAIT;
  assign last       = cnt_q == CW'(TIMEOUT - 1);
  assign start      = !waiting && access && aligned;
  assign misaligned = !waiting && access && !aligned;
  // an ack on the final wait cycle wins over the timeout
  assign done       = waiting && (mem_ack_i || last);
  assign stall_o    = start || (waiting && !done);
  assign flush_o    = ((IsBranch_i & zero_i) | IsJump_i) & ~stall_o;
  assign target_o   = pc_i;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;
  assign RegWrite_o  = rw_q;
  assign MemToReg_o  = m2r_q;
  assign ALUResult_o = alu_q;
  assign ReadData_o  = rd_q;
  assign WriteReg_o  = wr_q;
  always_comb begin
    state_d = start ? WAIT : done ? IDLE : state_q;
    cnt_d   = (waiting && !done) ? cnt_q + 1'b1 : '0;
    req_d   = start || (waiting && !done);
    we_d    = start ? MemWrite_i : we_q;
    addr_d  = start ? ALUResult_i : addr_q;
    wdata_d = start ? WriteData_i : wdata_q;
    err_d   = err_q || misaligned || (waiting && !mem_ack_i && last);
    rd_d    = (waiting && mem_ack_i) ? (we_q ? rd_q : mem_rdata_i) :
              (done || misaligned) ? '0 : rd_q;
    rw_d    = !stall_o && RegWrite_i;
    m2r_d   = !stall_o && MemToReg_i;
    alu_d   = stall_o ? alu_q : ALUResult_i;
    wr_d    = stall_o ? wr_q : WriteReg_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      alu_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
endmodule
